// File: rtl/vga_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_pkg : shared VGA timing defaults and pixel/coordinate types
// Rev 1.0
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  typedef logic [9:0] coord_t;
  typedef logic [7:0] color_t;

  typedef struct packed {
    color_t r;
    color_t g;
    color_t b;
  } rgb_t;

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_timing_gen_if : colour-mapper and DAC-side signals of the VGA timer
// Rev 1.0
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
  import vga_pkg::*;

  color_t Red_in;
  color_t Green_in;
  color_t Blue_in;
  coord_t DrawX;
  coord_t DrawY;
  color_t VGA_R;
  color_t VGA_G;
  color_t VGA_B;
  logic   VGA_HS;
  logic   VGA_VS;
  logic   VGA_BLANK_N;
  logic   VGA_SYNC_N;
  logic   VGA_CLK;
  logic   frame_tick;

  modport master (
    input  Red_in, Green_in, Blue_in,
    output DrawX, DrawY, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
           VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_tick
  );

  modport slave (
    output Red_in, Green_in, Blue_in,
    input  DrawX, DrawY, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
           VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_tick
  );

endinterface
`default_nettype wire

// File: rtl/vga_timing_gen_wrap_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_wrap_counter : enabled 0..MAX counter with a same-cycle wrap flag
// Rev 1.0
// ---------------------------------------------------------------------------
module vga_wrap_counter #(
  parameter int MAX   = 799,
  parameter int WIDTH = 10
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             en,
  output logic      [WIDTH-1:0] count,
  output logic                  wrap
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // wrap is qualified by en so it can directly enable a cascaded counter
  always_comb begin
    wrap    = en && (count_q == WIDTH'(MAX));
    count_d = count_q;
    if (wrap) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_timing_gen : VGA raster timing with pixel-aligned registered RGB/sync
// Optional macro VGA_TEST_PATTERN_EN replaces the RGB inputs with colour bars.
// Rev 1.0
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  wire logic         Clk,
  input  wire logic         Reset_n,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DC_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam coord_t C_HS_START = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t C_HS_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t C_VS_START = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t C_VS_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  if (H_TOTAL > 1024) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end
  if (CLK_DIV < 2) begin : g_clk_div_chk
    $error("vga_timing_gen: CLK_DIV must be at least 2");
  end

  logic [DC_W-1:0] dc_q;
  logic [DC_W-1:0] dc_d;
  logic            pix_ce;
  logic            vga_clk_q;
  logic            vga_clk_d;

  // VGA_CLK tracks the upcoming divider phase so its rising edge sits mid-pixel
  always_comb begin
    pix_ce    = (dc_q == DC_W'(CLK_DIV - 1));
    dc_d      = pix_ce ? '0 : dc_q + DC_W'(1);
    vga_clk_d = (dc_d >= DC_W'(CLK_DIV / 2));
  end

  coord_t hc;
  coord_t vc;
  logic   h_wrap;
  logic   v_wrap;
  logic   v_en;

  assign v_en = pix_ce && h_wrap;

  vga_wrap_counter #(
    .MAX   (H_TOTAL - 1),
    .WIDTH ($bits(coord_t))
  ) u_hcnt (
    .clk   (Clk),
    .rst_n (Reset_n),
    .en    (pix_ce),
    .count (hc),
    .wrap  (h_wrap)
  );

  vga_wrap_counter #(
    .MAX   (V_TOTAL - 1),
    .WIDTH ($bits(coord_t))
  ) u_vcnt (
    .clk   (Clk),
    .rst_n (Reset_n),
    .en    (v_en),
    .count (vc),
    .wrap  (v_wrap)
  );

  rgb_t rgb_q;
  rgb_t rgb_d;
  rgb_t src_rgb;
  logic vis;
  logic hs_q;
  logic hs_d;
  logic vs_q;
  logic vs_d;
  logic blank_n_q;
  logic blank_n_d;
  logic frame_tick_q;
  logic frame_tick_d;

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar_idx;

  always_comb begin
    bar_idx   = 3'((32'(hc) * 32'd8) / 32'(H_VISIBLE));
    src_rgb.r = {8{bar_idx[2]}};
    src_rgb.g = {8{bar_idx[1]}};
    src_rgb.b = {8{bar_idx[0]}};
  end
`else
  always_comb begin
    src_rgb.r = vga.Red_in;
    src_rgb.g = vga.Green_in;
    src_rgb.b = vga.Blue_in;
  end
`endif

  // Output stage samples the coordinate currently on DrawX/DrawY, so every
  // DAC-side signal lags the counters by exactly one pixel.
  always_comb begin
    vis          = (hc < coord_t'(H_VISIBLE)) && (vc < coord_t'(V_VISIBLE));
    rgb_d        = rgb_q;
    hs_d         = hs_q;
    vs_d         = vs_q;
    blank_n_d    = blank_n_q;
    frame_tick_d = v_wrap;
    if (pix_ce) begin
      rgb_d     = vis ? src_rgb : '0;
      blank_n_d = vis;
      hs_d      = !((hc >= C_HS_START) && (hc < C_HS_END));
      vs_d      = !((vc >= C_VS_START) && (vc < C_VS_END));
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dc_q         <= '0;
      vga_clk_q    <= 1'b0;
      rgb_q        <= '0;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      blank_n_q    <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      dc_q         <= dc_d;
      vga_clk_q    <= vga_clk_d;
      rgb_q        <= rgb_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      blank_n_q    <= blank_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign vga.DrawX       = hc;
  assign vga.DrawY       = vc;
  assign vga.VGA_R       = rgb_q.r;
  assign vga.VGA_G       = rgb_q.g;
  assign vga.VGA_B       = rgb_q.b;
  assign vga.VGA_HS      = hs_q;
  assign vga.VGA_VS      = vs_q;
  assign vga.VGA_BLANK_N = blank_n_q;
  assign vga.VGA_SYNC_N  = 1'b0;
  assign vga.VGA_CLK     = vga_clk_q;
  assign vga.frame_tick  = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vga_timing_gen : scoreboard bench on a reduced-size raster
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int CD = 4;
  localparam int HV = 8;
  localparam int HF = 2;
  localparam int HS = 2;
  localparam int HB = 2;
  localparam int VV = 4;
  localparam int VF = 1;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME_CLK = HT * VT * CD;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       bl;
  } exp_t;

  logic clk;
  logic rst_n;

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .CLK_DIV   (CD),
    .H_VISIBLE (HV),
    .H_FRONT   (HF),
    .H_SYNC    (HS),
    .H_BACK    (HB),
    .V_VISIBLE (VV),
    .V_FRONT   (VF),
    .V_SYNC    (VS),
    .V_BACK    (VB)
  ) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .vga     (vif.master)
  );

  always #5 clk = ~clk;

  int         n_vec;
  int         n_err;
  int         dc_m;
  int         hc_m;
  int         vc_m;
  int         cyc;
  int         last_tick;
  int         n_ticks;
  logic [7:0] r_in;
  logic [7:0] g_in;
  logic [7:0] b_in;
  exp_t       cur_exp;
  exp_t       sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, x=%0d y=%0d)",
               tag, got, exp, cyc, hc_m, vc_m);
    end
  endtask

  function automatic exp_t model_out(input int x, input int y,
                                     input logic [7:0] r, input logic [7:0] g,
                                     input logic [7:0] b);
    exp_t e;
    logic vis;
    int   bar;
    vis = (x < HV) && (y < VV);
    bar = (x * 8) / HV;
`ifdef VGA_TEST_PATTERN_EN
    e.r = (vis && bar[2]) ? 8'hFF : 8'h00;
    e.g = (vis && bar[1]) ? 8'hFF : 8'h00;
    e.b = (vis && bar[0]) ? 8'hFF : 8'h00;
`else
    e.r = vis ? r : 8'h00;
    e.g = vis ? g : 8'h00;
    e.b = vis ? b : 8'h00;
`endif
    e.hs = !((x >= HV + HF) && (x < HV + HF + HS));
    e.vs = !((y >= VV + VF) && (y < VV + VF + VS));
    e.bl = vis;
    return e;
  endfunction

  // Colour mapper stand-in; blanking gets junk since it must be ignored there
  task automatic drive_inputs();
    if ((hc_m < HV) && (vc_m < VV)) begin
      r_in = hc_m[7:0];
      g_in = vc_m[7:0];
      b_in = 8'hA5;
    end else begin
      r_in = 8'($urandom);
      g_in = 8'($urandom);
      b_in = 8'($urandom);
    end
    vif.Red_in   = r_in;
    vif.Green_in = g_in;
    vif.Blue_in  = b_in;
  endtask

  task automatic model_reset();
    dc_m      = 0;
    hc_m      = 0;
    vc_m      = 0;
    last_tick = -1;
    sb.delete();
    cur_exp   = '{r: 8'h00, g: 8'h00, b: 8'h00, hs: 1'b1, vs: 1'b1, bl: 1'b0};
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_drawx"}, 32'(vif.DrawX), 32'd0);
    check_eq({tag, "_drawy"}, 32'(vif.DrawY), 32'd0);
    check_eq({tag, "_rgb"}, {8'h00, vif.VGA_R, vif.VGA_G, vif.VGA_B}, 32'd0);
    check_eq({tag, "_hs"}, 32'(vif.VGA_HS), 32'd1);
    check_eq({tag, "_vs"}, 32'(vif.VGA_VS), 32'd1);
    check_eq({tag, "_blank_n"}, 32'(vif.VGA_BLANK_N), 32'd0);
    check_eq({tag, "_vga_clk"}, 32'(vif.VGA_CLK), 32'd0);
    check_eq({tag, "_tick"}, 32'(vif.frame_tick), 32'd0);
  endtask

  task automatic step();
    logic pce;
    logic ft;
    pce = (dc_m == CD - 1);
    if (pce) sb.push_back(model_out(hc_m, vc_m, r_in, g_in, b_in));
    @(posedge clk);
    #1;
    cyc++;
    ft   = pce && (hc_m == HT - 1) && (vc_m == VT - 1);
    dc_m = pce ? 0 : dc_m + 1;
    if (pce) begin
      if (hc_m == HT - 1) begin
        hc_m = 0;
        vc_m = (vc_m == VT - 1) ? 0 : vc_m + 1;
      end else begin
        hc_m = hc_m + 1;
      end
      if (sb.size() == 0) check_eq("sb_underflow", 32'd1, 32'd0);
      else cur_exp = sb.pop_front();
    end
    check_eq("drawx", 32'(vif.DrawX), 32'(hc_m));
    check_eq("drawy", 32'(vif.DrawY), 32'(vc_m));
    check_eq("vga_clk", 32'(vif.VGA_CLK), 32'(dc_m >= CD / 2));
    check_eq("frame_tick", 32'(vif.frame_tick), 32'(ft));
    check_eq("vga_r", 32'(vif.VGA_R), 32'(cur_exp.r));
    check_eq("vga_g", 32'(vif.VGA_G), 32'(cur_exp.g));
    check_eq("vga_b", 32'(vif.VGA_B), 32'(cur_exp.b));
    check_eq("vga_hs", 32'(vif.VGA_HS), 32'(cur_exp.hs));
    check_eq("vga_vs", 32'(vif.VGA_VS), 32'(cur_exp.vs));
    check_eq("blank_n", 32'(vif.VGA_BLANK_N), 32'(cur_exp.bl));
    check_eq("sync_n", 32'(vif.VGA_SYNC_N), 32'd0);
    if (vif.frame_tick) begin
      n_ticks++;
      if (last_tick >= 0) check_eq("tick_spacing", 32'(cyc - last_tick), 32'(FRAME_CLK));
      last_tick = cyc;
    end
    drive_inputs();
  endtask

  initial begin
    clk     = 1'b0;
    rst_n   = 1'b0;
    n_vec   = 0;
    n_err   = 0;
    cyc     = 0;
    n_ticks = 0;
    model_reset();
    drive_inputs();

    repeat (3) @(posedge clk);
    #1;
    check_reset("por");

    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive_inputs();

    for (int i = 0; i < 2 * FRAME_CLK + 50; i++) step();

    // Land inside the horizontal sync of a visible line, then reset mid-cycle
    for (int i = 0; i < FRAME_CLK; i++) begin
      if ((hc_m == HV + HF + 1) && (vc_m == 2) && (dc_m == 1)) break;
      step();
    end
    check_eq("reached_reset_point", 32'(hc_m), 32'(HV + HF + 1));
    check_eq("hs_before_reset", 32'(vif.VGA_HS), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("held");
    rst_n = 1'b1;
    model_reset();
    drive_inputs();

    for (int i = 0; i < 2 * FRAME_CLK + 20; i++) step();

    check_eq("ticks_seen", 32'(n_ticks >= 4), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
